// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field positions,
// FSM state encodings and small opcode classification helpers.
package decode_stage_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  function automatic logic isLegal(input logic [3:0] op);
    return op <= OP_STORE;
  endfunction

  function automatic logic usesRs2(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

  // CMP and STORE produce no register result.
  function automatic logic writesRd(input logic [3:0] op);
    return (op < OP_CMP) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, ALU-side and writeback signals of the decode stage.
interface decode_stage_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_src;
  logic [1:0]  out_rd;
  logic        out_wr;
  logic [7:0]  st_data;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        illegal_op;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, alu_a, alu_b, alu_opcode, alu_src,
           out_rd, out_wr, st_data, illegal_op
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, alu_a, alu_b, alu_opcode, alu_src,
           out_rd, out_wr, st_data, illegal_op
  );
endinterface

// File: rtl/decode_stage_regfile_4x8.sv
// Architectural register file: three read ports (rs1, rs2, store data) and one
// write port; a read of the register being written this cycle returns the new data.
module regfile_4x8 #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr1_i,
  input  logic [1:0] raddr2_i,
  input  logic [1:0] raddr3_i,
  output logic [7:0] rdata1_o,
  output logic [7:0] rdata2_o,
  output logic [7:0] rdata3_o
);

  logic [7:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: 8'h00};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
  assign rdata3_o = (we_i && waddr_i == raddr3_i) ? wdata_i : regs_q[raddr3_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: reads operands, tracks in-flight destinations with a pending-bit
// scoreboard, stalls on read-after-write hazards and holds one issued op for the ALU.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 4
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);

  logic [3:0] opc;
  logic [1:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic [7:0] rs1Data, rs2Data, rdData;

  assign opc = bus.in_instr[OPC_MSB:OPC_LSB];
  assign rd  = bus.in_instr[RD_MSB:RD_LSB];
  assign rs1 = bus.in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = bus.in_instr[RS2_MSB:RS2_LSB];
  assign imm = bus.in_instr[IMM_MSB:IMM_LSB];

  regfile_4x8 #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .raddr3_i (rd),
    .rdata1_o (rs1Data),
    .rdata2_o (rs2Data),
    .rdata3_o (rdData)
  );

  logic [1:0]       state_q, state_d;
  logic [NREGS-1:0] pending_q, pending_d, wbClear, issueSet, busy;
  logic             legal, hazard, inReady, outValid, transfer, issue;

  assign legal    = isLegal(opc);
  assign outValid = (state_q == ST_ISSUE);

  always_comb begin
    wbClear = '0;
    if (bus.wb_en) wbClear[bus.wb_addr] = 1'b1;
  end

  // A writeback landing this cycle resolves the dependency, thanks to the bypass.
  assign busy   = pending_q & ~wbClear;
  assign hazard = legal && (busy[rs1] ||
                            (usesRs2(opc) && busy[rs2]) ||
                            (opc == OP_STORE && busy[rd]));

  assign inReady  = !hazard && (!outValid || bus.out_ready);
  assign transfer = bus.in_valid && inReady;
  assign issue    = transfer && legal;

  always_comb begin
    issueSet = '0;
    if (issue && writesRd(opc)) issueSet[rd] = 1'b1;
  end

  assign pending_d = (pending_q & ~wbClear) | issueSet;

  always_comb begin
    if (issue)                           state_d = ST_ISSUE;
    else if (outValid && !bus.out_ready) state_d = ST_ISSUE;
    else if (bus.in_valid && hazard)     state_d = ST_STALL;
    else                                 state_d = ST_IDLE;
  end

  logic [7:0] aluA_q, aluB_q, stData_q;
  logic [3:0] opcode_q;
  logic [1:0] rd_q;
  logic       wr_q, illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      stData_q  <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      illegal_q <= transfer && !legal;
      if (issue) begin
        aluA_q   <= rs1Data;
        aluB_q   <= (opc >= OP_LOAD) ? imm : rs2Data;
        stData_q <= rdData;
        opcode_q <= opc;
        rd_q     <= rd;
        wr_q     <= writesRd(opc);
      end
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid;
  assign bus.alu_src    = outValid;
  assign bus.alu_a      = aluA_q;
  assign bus.alu_b      = aluB_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_wr     = wr_q;
  assign bus.st_data    = stData_q;
  assign bus.illegal_op = illegal_q;

endmodule
